// File: rtl/fll_cfg_bridge.sv
// ============================================================================
//  Module   : fll_cfg_bridge
//  Purpose  : Bridges register_interface config transactions from the SoC to
//             the FLL's 4-phase CFGREQ/CFGACK configuration handshake. Offsets
//             0x00..0x0C map onto the four FLL config registers. Offset 0x10 is
//             a local read-only STATUS word {30'b0, lock, busy}. Each handshake
//             phase has a cycle budget, so a dead FLL cannot hang the bus.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_WIDTH     : width of reg_addr_i (>= 5)
//    TIMEOUT_CYCLES : clk_i cycles allowed per handshake phase, 0 = no timeout
//  Build option
//    FLL_CFG_SYNC_EN: when defined, fll_ack_i and fll_lock_i pass through
//                     2-flop synchronizers (FLL config port on another clock).
//                     When undefined, both are used directly.
//  Ports
//    clk_i, rst_i            : clock, asynchronous active-high reset
//    reg_valid_i/write/addr/ : SoC request (held until reg_ready_o)
//    wdata/wstrb
//    reg_rdata_o/ready/error : one-cycle response strobe with data and error
//    fll_req_o/ack_i         : CFGREQ / CFGACK handshake
//    fll_add_o/data_o/wrn_o  : CFGAD / CFGD / CFGWEB (1=read)
//    fll_r_data_i            : CFGQ read data
//    fll_lock_i              : FLL LOCK
// ============================================================================
`default_nettype none

module fll_cfg_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_valid_i,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    input  logic [3:0]            reg_wstrb_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_ready_o,
    output logic                  reg_error_o,
    output logic                  fll_req_o,
    input  logic                  fll_ack_i,
    output logic [1:0]            fll_add_o,
    output logic [31:0]           fll_data_o,
    output logic                  fll_wrn_o,
    input  logic [31:0]           fll_r_data_i,
    input  logic                  fll_lock_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // The counter only needs to reach TIMEOUT_CYCLES-1: a phase times out on
    // its TIMEOUT_CYCLES-th cycle.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              wrn_q, wrn_d;
    logic [1:0]        add_q, add_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       cap_q, cap_d;      // response data gathered during the access
    logic              err_q, err_d;      // sticky error for the current access
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              ack_s;
    logic              lock_s;
    logic              busy;
    logic              is_fll;
    logic              is_stat;
    logic              dec_err;
    logic              timeout;

`ifdef FLL_CFG_SYNC_EN
    logic [1:0] ack_sync_q;
    logic [1:0] lock_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            ack_sync_q  <= {ack_sync_q[0], fll_ack_i};
            lock_sync_q <= {lock_sync_q[0], fll_lock_i};
        end
    end

    assign ack_s  = ack_sync_q[1];
    assign lock_s = lock_sync_q[1];
`else
    assign ack_s  = fll_ack_i;
    assign lock_s = fll_lock_i;
`endif

    // Address decode: aligned offsets 0x00..0x0C are FLL registers, 0x10 is STATUS.
    assign is_fll  = (reg_addr_i[ADDR_WIDTH-1:4] == '0) && (reg_addr_i[1:0] == 2'b00);
    assign is_stat = (reg_addr_i == ADDR_WIDTH'(32'h10));
    assign dec_err = !(is_fll || is_stat)
                   || (reg_write_i && is_stat)
                   || (reg_write_i && is_fll && (reg_wstrb_i != 4'hF));

    assign busy    = (state_q != S_IDLE);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        wrn_d   = wrn_q;
        add_d   = add_q;
        data_d  = data_q;
        cap_d   = cap_q;
        err_d   = err_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                // While the response strobe is out, the master still holds
                // valid for the request just answered; do not accept it twice.
                if (reg_valid_i && !ready_q) begin
                    if (dec_err) begin
                        err_d   = 1'b1;
                        cap_d   = 32'h0;
                        state_d = S_RESP;
                    end else if (is_stat) begin
                        err_d   = 1'b0;
                        cap_d   = {30'b0, lock_s, busy};
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cap_d   = 32'h0;
                        add_d   = reg_addr_i[3:2];
                        data_d  = reg_wdata_i;
                        wrn_d   = ~reg_write_i;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    if (wrn_q) begin
                        cap_d = fll_r_data_i;
                    end
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REL;
                end else if (timeout) begin
                    // Abandon the request but still wait for ack release.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    state_d = S_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                error_d = err_q;
                rdata_d = err_q ? 32'h0 : cap_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            wrn_q   <= 1'b1;
            add_q   <= 2'b00;
            data_q  <= 32'h0;
            cap_q   <= 32'h0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wrn_q   <= wrn_d;
            add_q   <= add_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

    assign fll_req_o   = req_q;
    assign fll_wrn_o   = wrn_q;
    assign fll_add_o   = add_q;
    assign fll_data_o  = data_q;
    assign reg_ready_o = ready_q;
    assign reg_error_o = error_q;
    assign reg_rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_fll_cfg_bridge.sv
// ============================================================================
//  Module   : tb_fll_cfg_bridge
//  Purpose  : Self-checking bench for fll_cfg_bridge. An FLL device model with
//             a 4-entry register file answers the handshake with random
//             delays. A scoreboard derives expected responses from the address
//             map rules and its own shadow copy of the FLL registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fll_cfg_bridge;

    localparam int unsigned C_TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_valid_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [31:0] reg_addr_i  = 32'h0;
    logic [31:0] reg_wdata_i = 32'h0;
    logic [3:0]  reg_wstrb_i = 4'h0;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;
    logic        reg_error_o;
    logic        fll_req_o;
    logic        fll_ack_i    = 1'b0;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_wrn_o;
    logic [31:0] fll_r_data_i = 32'h0;
    logic        fll_lock_i   = 1'b0;

    fll_cfg_bridge #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (C_TO)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_valid_i  (reg_valid_i),
        .reg_write_i  (reg_write_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_wstrb_i  (reg_wstrb_i),
        .reg_rdata_o  (reg_rdata_o),
        .reg_ready_o  (reg_ready_o),
        .reg_error_o  (reg_error_o),
        .fll_req_o    (fll_req_o),
        .fll_ack_i    (fll_ack_i),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_r_data_i (fll_r_data_i),
        .fll_lock_i   (fll_lock_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int   req_rises = 0;
    int   req_high  = 0;
    logic req_prev  = 1'b0;

    always @(negedge clk) begin
        if (fll_req_o) req_high <= req_high + 1;
        if (fll_req_o && !req_prev) req_rises <= req_rises + 1;
        req_prev <= fll_req_o;
    end

    // ---------------- FLL device model ----------------
    logic [31:0] fll_mem [4];
    logic [31:0] ref_regs[4];
    int          ack_dly  = 0;
    int          rel_dly  = 0;
    bit          fll_dead = 1'b0;
    logic [1:0]  exp_add  = 2'b0;
    logic        exp_wrn  = 1'b1;
    logic [31:0] exp_data = 32'h0;

    initial begin
        int          m_st;
        int          m_cnt;
        logic [34:0] snap;
        m_st  = 0;
        m_cnt = 0;
        snap  = '0;
        forever begin
            @(negedge clk);
            case (m_st)
                0: if (fll_req_o) begin
                    snap  = {fll_add_o, fll_wrn_o, fll_data_o};
                    m_cnt = ack_dly;
                    m_st  = 1;
                end
                1: if (!fll_req_o) begin
                    m_st = 0;
                end else if (!fll_dead && m_cnt == 0) begin
                    chk("fll_stable", {fll_add_o, fll_wrn_o, fll_data_o}, snap);
                    chk("fll_add", fll_add_o, exp_add);
                    chk("fll_wrn", fll_wrn_o, exp_wrn);
                    if (!fll_wrn_o) chk("fll_data", fll_data_o, exp_data);
                    fll_r_data_i = fll_mem[fll_add_o];
                    if (!fll_wrn_o) fll_mem[fll_add_o] = fll_data_o;
                    fll_ack_i = 1'b1;
                    m_st      = 2;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                end
                2: if (!fll_req_o) begin
                    m_cnt = rel_dly;
                    m_st  = 3;
                end
                default: if (m_cnt == 0) begin
                    fll_ack_i = 1'b0;
                    m_st      = 0;
                end else begin
                    m_cnt--;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_resp(input bit wr, input logic [31:0] a, input logic [3:0] s,
                                     input bit lk, output bit err, output logic [31:0] rd,
                                     output bit fll);
        fll = 1'b0;
        err = 1'b0;
        rd  = 32'h0;
        if (a[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (a < 32'h10) begin
            if (wr && s != 4'hF) err = 1'b1;
            else begin
                fll = 1'b1;
                rd  = wr ? 32'h0 : ref_regs[a[3:2]];
            end
        end else if (a == 32'h10) begin
            if (wr) err = 1'b1;
            else    rd  = {30'b0, lk, 1'b0};
        end else begin
            err = 1'b1;
        end
    endfunction

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rd, output logic er,
                          output int lat, output int rises);
        int r0;
        r0 = req_rises;
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!reg_ready_o && lat < 300);
        chk("ready_seen", reg_ready_o, 1'b1);
        rd = reg_rdata_o;
        er = reg_error_o;
        chk("req_low_at_ready", fll_req_o, 1'b0);
        reg_valid_i = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", reg_ready_o, 1'b0);
        rises = req_rises - r0;
    endtask

    task automatic run_and_check(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        bit          e_err;
        bit          e_fll;
        logic [31:0] e_rd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rises;
        ref_resp(wr, addr, strb, fll_lock_i, e_err, e_rd, e_fll);
        exp_add  = addr[3:2];
        exp_wrn  = ~wr;
        exp_data = wdata;
        do_txn(wr, addr, wdata, strb, rd, er, lat, rises);
        chk("error", er, e_err);
        chk("rdata", rd, e_rd);
        if (e_fll) begin
            chk("one_req", rises, 1);
            if (wr) ref_regs[addr[3:2]] = wdata;
        end else begin
            chk("local_latency", lat, 2);
            chk("no_req", rises, 0);
        end
    endtask

    task automatic set_lock(input logic lk);
        fll_lock_i = lk;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rises;
        int          hc0;
        int          guard;
        bit          seen;
        logic [31:0] a;
        logic [31:0] v;

        for (int i = 0; i < 4; i++) begin
            v           = $urandom;
            fll_mem[i]  = v;
            ref_regs[i] = v;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", fll_req_o, 1'b0);
        chk("rst_wrn", fll_wrn_o, 1'b1);
        chk("rst_add", fll_add_o, 2'b00);
        chk("rst_data", fll_data_o, 32'h0);
        chk("rst_ready", reg_ready_o, 1'b0);
        chk("rst_error", reg_error_o, 1'b0);
        chk("rst_rdata", reg_rdata_o, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases
        fll_mem[1]  = 32'hA5A5_0001;
        ref_regs[1] = 32'hA5A5_0001;
        ack_dly = 3; rel_dly = 1;
        run_and_check(1'b0, 32'h04, 32'h0, 4'hF);
        run_and_check(1'b1, 32'h08, 32'h1234_5678, 4'hF);
        run_and_check(1'b0, 32'h08, 32'h0, 4'hF);
        set_lock(1'b1);
        run_and_check(1'b0, 32'h10, 32'h0, 4'hF);
        set_lock(1'b0);
        run_and_check(1'b0, 32'h10, 32'h0, 4'hF);
        run_and_check(1'b0, 32'h14, 32'h0, 4'hF);
        run_and_check(1'b0, 32'h02, 32'h0, 4'hF);
        run_and_check(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        run_and_check(1'b1, 32'h00, 32'hDEAD_BEEF, 4'h3);

        // Timeout: FLL never acknowledges
        fll_dead = 1'b1;
        hc0 = req_high;
        do_txn(1'b0, 32'h00, 32'h0, 4'hF, rd, er, lat, rises);
        chk("to_req_cycles", req_high - hc0, C_TO);
        chk("to_error", er, 1'b1);
        chk("to_rdata", rd, 32'h0);
        fll_dead = 1'b0;
        repeat (2) @(negedge clk);
        run_and_check(1'b0, 32'h04, 32'h0, 4'hF);

        // Reset while the request is outstanding
        ack_dly = 40;
        exp_add = 2'd3; exp_wrn = 1'b1;
        reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 32'h0C; reg_wstrb_i = 4'hF;
        guard = 0;
        while (!fll_req_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_test_req_up", fll_req_o, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_req_drop", fll_req_o, 1'b0);
        reg_valid_i = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (reg_ready_o) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reg_ready_o) seen = 1'b1;
        end
        chk("rst_no_ready", seen, 1'b0);
        ack_dly = 2;
        run_and_check(1'b0, 32'h10, 32'h0, 4'hF);
        run_and_check(1'b0, 32'h0C, 32'h0, 4'hF);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            ack_dly = $urandom_range(0, 5);
            rel_dly = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) set_lock(1'($urandom));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, 3)) << 2;
                4:          a = 32'h10;
                5:          a = 32'h14;
                6:          a = $urandom & 32'hFFFF_FFFC;
                7:          a = (32'($urandom_range(0, 4)) << 2) | 32'($urandom_range(1, 3));
                default:    a = 32'($urandom_range(0, 3)) << 2;
            endcase
            run_and_check(1'($urandom), a, $urandom,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
